// File: rtl/led_pkg.sv
// Shared types and cycle-count helpers for the LED frame scheduler.
package led_pkg;

  localparam int ColorWidth = 8;

  typedef struct packed {
    logic [ColorWidth-1:0] g;
    logic [ColorWidth-1:0] r;
    logic [ColorWidth-1:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    WAIT_RST,
    FEED,
    HOLD
  } sched_state_t;

  function automatic longint hz_to_cycles(longint clk_hz, longint hz);
    return clk_hz / hz;
  endfunction

  function automatic longint us_to_cycles(longint clk_hz, longint us);
    return (us * clk_hz) / 64'd1_000_000;
  endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-banked colour store: one write port, one registered read port, bank bit is the address MSB.
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int IW = 5
) (
  input  logic          clk_in,
  input  logic          wr_en_in,
  input  logic          wr_bank_in,
  input  logic [IW-1:0] wr_addr_in,
  input  rgb_t          wr_data_in,
  input  logic          rd_bank_in,
  input  logic [IW-1:0] rd_addr_in,
  output rgb_t          rd_data_out
);

  rgb_t mem [2**(IW+1)];

  always_ff @(posedge clk_in) begin
    if (wr_en_in) mem[{wr_bank_in, wr_addr_in}] <= wr_data_in;
    rd_data_out <= mem[{rd_bank_in, rd_addr_in}];
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Frame sequencer for a WS2812B strand driver: refresh timing, bank swapping, colour streaming.
// Build option LED_BRIGHTNESS_EN adds brightness_in and a scaling stage (one extra cycle of latency).
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int CLOCK_SPEED = 100_000_000,
  parameter int NUM_LEDS    = 20,
  parameter int FRAME_HZ    = 60,
  parameter int RESET_US    = 60,
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          enable_in,
  input  logic          wr_en_in,
  input  logic [IW-1:0] wr_addr_in,
  input  logic [23:0]   wr_data_in,
  input  logic          swap_req_in,
  output logic          swap_pending_out,
  input  logic          led_req_valid_in,
  input  logic [IW-1:0] led_req_idx_in,
  output logic [7:0]    drv_green_out,
  output logic [7:0]    drv_red_out,
  output logic [7:0]    drv_blue_out,
  output logic          drv_color_valid_out,
  output logic          drv_force_reset_out,
  output logic          frame_start_out,
  output logic          busy_out,
  output logic          overrun_out,
  output logic          idx_err_out
`ifdef LED_BRIGHTNESS_EN
  ,
  input  logic [7:0]    brightness_in
`endif
);

  localparam int FrameCyc = int'(hz_to_cycles(longint'(CLOCK_SPEED), longint'(FRAME_HZ)));
  localparam int ResetCyc = int'(us_to_cycles(longint'(CLOCK_SPEED), longint'(RESET_US)));
  localparam int FW = (FrameCyc > 2) ? $clog2(FrameCyc) : 1;
  localparam int RW = (ResetCyc > 2) ? $clog2(ResetCyc) : 1;
  localparam logic [FW-1:0] FrameLast = FW'(FrameCyc - 1);
  localparam logic [RW-1:0] RstLast   = RW'(ResetCyc - 1);
  localparam logic [IW-1:0] LedLast   = IW'(NUM_LEDS - 1);

  sched_state_t  state, state_nxt;
  logic          front_bank;
  logic [FW-1:0] frame_cnt;
  logic [RW-1:0] rst_cnt;
  logic [IW-1:0] next_idx;
  logic          issue;
  logic [IW-1:0] issue_idx;
  logic          idx_mismatch;
  rgb_t          rd_data_p1;
  logic          vld_p1;
  rgb_t          drv_color_q;

`ifdef LED_BRIGHTNESS_EN
  rgb_t color_p2;
  logic vld_p2;

  function automatic logic [7:0] scale_ch(logic [7:0] c, logic [7:0] k);
    logic [15:0] prod;
    prod = c * k;
    return prod[15:8];
  endfunction

  function automatic rgb_t scale_rgb(rgb_t c, logic [7:0] k);
    rgb_t s;
    s.g = scale_ch(c.g, k);
    s.r = scale_ch(c.r, k);
    s.b = scale_ch(c.b, k);
    return s;
  endfunction
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (enable_in) state_nxt = OPEN;
      OPEN:     state_nxt = WAIT_RST;
      WAIT_RST: if (rst_cnt == RstLast) state_nxt = (NUM_LEDS == 1) ? HOLD : FEED;
      FEED:     if (issue && next_idx == LedLast) state_nxt = HOLD;
      HOLD:     if (frame_cnt == FrameLast) state_nxt = enable_in ? OPEN : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // LED 0 is issued unsolicited on the last latch-wait cycle; the rest follow driver requests.
  always_comb begin
    issue        = 1'b0;
    issue_idx    = next_idx;
    idx_mismatch = 1'b0;
    case (state)
      WAIT_RST: begin
        issue     = (rst_cnt == RstLast);
        issue_idx = '0;
      end
      FEED: begin
        issue        = led_req_valid_in && (led_req_idx_in == next_idx);
        idx_mismatch = led_req_valid_in && (led_req_idx_in != next_idx);
      end
      default: ;
    endcase
  end

  assign drv_force_reset_out = (state == OPEN);
  assign frame_start_out     = (state == OPEN);
  assign busy_out            = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      front_bank       <= 1'b0;
      swap_pending_out <= 1'b0;
      overrun_out      <= 1'b0;
      idx_err_out      <= 1'b0;
      frame_cnt        <= '0;
      rst_cnt          <= '0;
      next_idx         <= '0;
    end else begin
      if (state == OPEN) begin
        front_bank       <= front_bank ^ swap_pending_out;
        swap_pending_out <= swap_req_in;
        frame_cnt        <= FW'(1);
        rst_cnt          <= '0;
        next_idx         <= '0;
      end else begin
        if (swap_req_in)             swap_pending_out <= 1'b1;
        if (frame_cnt != FrameLast)  frame_cnt <= frame_cnt + FW'(1);
      end
      if (state == WAIT_RST) rst_cnt <= rst_cnt + RW'(1);
      if (issue)             next_idx <= issue_idx + IW'(1);
      if ((state == WAIT_RST || state == FEED) && frame_cnt == FrameLast) overrun_out <= 1'b1;
      if (idx_mismatch)      idx_err_out <= 1'b1;
    end
  end

  // p0: address presented this cycle; p1: RAM data registered inside the buffer
  led_frame_buffer #(.IW(IW)) u_buf (
    .clk_in      (clk_in),
    .wr_en_in    (wr_en_in),
    .wr_bank_in  (~front_bank),
    .wr_addr_in  (wr_addr_in),
    .wr_data_in  (rgb_t'(wr_data_in)),
    .rd_bank_in  (front_bank),
    .rd_addr_in  (issue_idx),
    .rd_data_out (rd_data_p1)
  );

`ifdef LED_BRIGHTNESS_EN
  // p2: brightness-scaled colour
  always_ff @(posedge clk_in) begin
    color_p2 <= scale_rgb(rd_data_p1, brightness_in);
  end
`endif

  // Output register: colour and valid pulse to the driver
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      vld_p1              <= 1'b0;
      drv_color_q         <= '0;
      drv_color_valid_out <= 1'b0;
`ifdef LED_BRIGHTNESS_EN
      vld_p2              <= 1'b0;
`endif
    end else begin
      vld_p1 <= issue;
`ifdef LED_BRIGHTNESS_EN
      vld_p2              <= vld_p1;
      drv_color_q         <= color_p2;
      drv_color_valid_out <= vld_p2;
`else
      drv_color_q         <= rd_data_p1;
      drv_color_valid_out <= vld_p1;
`endif
    end
  end

  assign drv_green_out = drv_color_q.g;
  assign drv_red_out   = drv_color_q.r;
  assign drv_blue_out  = drv_color_q.b;

endmodule
